// File: rtl/snn_fold_cu_if.sv
// Handshake bundle between the fetch logic, the spiking compute unit and the output spike buffer.
// The slave modport is the compute unit's view; the master modport is the producer/consumer side.
interface snn_fold_cu_if #(
    parameter int NUM_PES      = 9,
    parameter int NUM_CHANNELS = 16,
    parameter int WEIGHT_W     = 8,
    parameter int TS_W         = 4
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [NUM_PES*NUM_CHANNELS-1:0]        in_spikes;
    logic [NUM_PES*NUM_CHANNELS*WEIGHT_W-1:0] in_weights;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [NUM_PES-1:0]                     out_spikes;
    logic [TS_W-1:0]                        out_ts;

    modport master (
        output in_valid, in_spikes, in_weights, out_ready,
        input  in_ready, out_valid, out_spikes, out_ts
    );

    modport slave (
        input  in_valid, in_spikes, in_weights, out_ready,
        output in_ready, out_valid, out_spikes, out_ts
    );
endinterface

// File: rtl/snn_fold_cu.sv
// Folded integrate-and-fire compute unit: accumulates fold beats per timestep, then fires once.
// Optional SNN_LEAK_EN adds cfg_leak_shift and a shift-based leak term in the membrane update.
module snn_fold_cu #(
    parameter int NUM_PES      = 9,
    parameter int NUM_CHANNELS = 16,
    parameter int MAX_FOLDS    = 4,
    parameter int WEIGHT_W     = 8,
    parameter int VMEM_W       = 12,
    parameter int TS_W         = 4
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             start,
    input  logic [$clog2(MAX_FOLDS+1)-1:0]   cfg_num_folds,
    input  logic [TS_W-1:0]                  cfg_num_ts,
    input  logic [VMEM_W-2:0]                cfg_vth,
    input  logic                             cfg_reset_mode,
`ifdef SNN_LEAK_EN
    input  logic [3:0]                       cfg_leak_shift,
`endif
    snn_fold_cu_if.slave                     bus,
    output logic                             done,
    output logic                             cfg_err
);
    localparam int FOLD_W = $clog2(MAX_FOLDS+1);
    localparam int PSUM_W = WEIGHT_W + $clog2(NUM_CHANNELS*MAX_FOLDS);
    localparam int SUM_W  = ((PSUM_W > VMEM_W) ? PSUM_W : VMEM_W) + 2;
    localparam logic signed [VMEM_W-1:0] VLIM = {1'b0, {(VMEM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]  SLIM = SUM_W'(VLIM);

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

    state_t                     state, state_next;
    logic [FOLD_W-1:0]          folds_q, fold_cnt;
    logic [TS_W-1:0]            ts_q, ts_cnt;
    logic [VMEM_W-2:0]          vth_q;
    logic                       mode_q;
    logic [NUM_PES-1:0]         spikes_q, fire_vec;
    logic signed [PSUM_W-1:0]   psum     [NUM_PES];
    logic signed [PSUM_W-1:0]   beat_sum [NUM_PES];
    logic signed [PSUM_W-1:0]   psum_new [NUM_PES];
    logic signed [VMEM_W-1:0]   vmem     [NUM_PES];
    logic signed [VMEM_W-1:0]   vsat     [NUM_PES];
    logic signed [VMEM_W-1:0]   vnext    [NUM_PES];
    logic signed [SUM_W-1:0]    vsum     [NUM_PES];
`ifdef SNN_LEAK_EN
    logic [3:0]                 leak_q;
    logic signed [VMEM_W-1:0]   leak     [NUM_PES];
`endif

    logic beat_acc, last_fold, handoff, last_ts;
    logic [FOLD_W-1:0] folds_eff;
    logic [TS_W-1:0]   ts_eff;

    assign beat_acc  = (state == ACCUM) && bus.in_valid;
    assign last_fold = (fold_cnt == folds_q - FOLD_W'(1));
    assign handoff   = (state == FIRE) && bus.out_ready;
    assign last_ts   = (ts_cnt == ts_q - TS_W'(1));

    assign folds_eff = (cfg_num_folds == '0) ? FOLD_W'(1) :
                       (cfg_num_folds > FOLD_W'(MAX_FOLDS)) ? FOLD_W'(MAX_FOLDS) : cfg_num_folds;
    assign ts_eff    = (cfg_num_ts == '0) ? TS_W'(1) : cfg_num_ts;

    assign bus.in_ready   = (state == ACCUM);
    assign bus.out_valid  = (state == FIRE);
    assign bus.out_spikes = spikes_q;
    assign bus.out_ts     = ts_cnt;

    // Per-PE beat sum and the candidate membrane update, which is only committed on the last fold beat
    always_comb begin
        for (int p = 0; p < NUM_PES; p++) begin
            beat_sum[p] = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (bus.in_spikes[p*NUM_CHANNELS + c])
                    beat_sum[p] = beat_sum[p] +
                        PSUM_W'($signed(bus.in_weights[(p*NUM_CHANNELS + c)*WEIGHT_W +: WEIGHT_W]));
            end
            psum_new[p] = psum[p] + beat_sum[p];
`ifdef SNN_LEAK_EN
            leak[p] = (leak_q == 4'd0) ? '0 : (vmem[p] >>> leak_q);
            vsum[p] = SUM_W'(vmem[p]) - SUM_W'(leak[p]) + SUM_W'(psum_new[p]);
`else
            vsum[p] = SUM_W'(vmem[p]) + SUM_W'(psum_new[p]);
`endif
            if (vsum[p] > SLIM)
                vsat[p] = VLIM;
            else if (vsum[p] < -SLIM)
                vsat[p] = -VLIM;
            else
                vsat[p] = vsum[p][VMEM_W-1:0];
            fire_vec[p] = (vsat[p] >= $signed({1'b0, vth_q}));
            if (!fire_vec[p])
                vnext[p] = vsat[p];
            else if (mode_q)
                vnext[p] = '0;
            else
                vnext[p] = vsat[p] - $signed({1'b0, vth_q});
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (beat_acc && last_fold) state_next = FIRE;
            FIRE:    if (bus.out_ready) state_next = last_ts ? IDLE : ACCUM;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and counters; vmem is written only on the ACCUM->FIRE step so stalls cannot re-apply it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            folds_q  <= '0;
            fold_cnt <= '0;
            ts_q     <= '0;
            ts_cnt   <= '0;
            vth_q    <= '0;
            mode_q   <= 1'b0;
            spikes_q <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef SNN_LEAK_EN
            leak_q   <= '0;
`endif
            for (int p = 0; p < NUM_PES; p++) begin
                psum[p] <= '0;
                vmem[p] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    folds_q  <= folds_eff;
                    ts_q     <= ts_eff;
                    vth_q    <= cfg_vth;
                    mode_q   <= cfg_reset_mode;
`ifdef SNN_LEAK_EN
                    leak_q   <= cfg_leak_shift;
`endif
                    fold_cnt <= '0;
                    ts_cnt   <= '0;
                    if (cfg_num_folds > FOLD_W'(MAX_FOLDS)) cfg_err <= 1'b1;
                    for (int p = 0; p < NUM_PES; p++) begin
                        psum[p] <= '0;
                        vmem[p] <= '0;
                    end
                end
                ACCUM: if (beat_acc) begin
                    fold_cnt <= fold_cnt + FOLD_W'(1);
                    for (int p = 0; p < NUM_PES; p++) psum[p] <= psum_new[p];
                    if (last_fold) begin
                        spikes_q <= fire_vec;
                        for (int p = 0; p < NUM_PES; p++) vmem[p] <= vnext[p];
                    end
                end
                FIRE: if (handoff) begin
                    fold_cnt <= '0;
                    for (int p = 0; p < NUM_PES; p++) psum[p] <= '0;
                    if (last_ts) done <= 1'b1;
                    else ts_cnt <= ts_cnt + TS_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_fold_cu.sv
// Scoreboard bench for snn_fold_cu: driver runs jobs against an arithmetic neuron model,
// a separate monitor pops expected spike vectors whenever the unit hands one off.
module tb_snn_fold_cu;
    localparam int NP = 9;
    localparam int NC = 16;
    localparam int MF = 4;
    localparam int WW = 8;
    localparam int VW = 12;
    localparam int TW = 4;
    localparam int VLIMIT = 2047;

    typedef struct {
        logic [NP-1:0] spk;
        logic [TW-1:0] ts;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cfg_num_folds = '0;
    logic [TW-1:0] cfg_num_ts = '0;
    logic [VW-2:0] cfg_vth = '0;
    logic        cfg_reset_mode = 1'b0;
    logic        done, cfg_err;

    int   checks = 0;
    int   fails  = 0;
    exp_t sbq[$];
    int   vmem_m [NP];
    int   psum_m [NP];
    int   sp [NP][NC];
    int   wt [NP][NC];
    bit   force_low = 1'b0;

    snn_fold_cu_if #(.NUM_PES(NP), .NUM_CHANNELS(NC), .WEIGHT_W(WW), .TS_W(TW)) bus ();

    snn_fold_cu #(
        .NUM_PES(NP), .NUM_CHANNELS(NC), .MAX_FOLDS(MF),
        .WEIGHT_W(WW), .VMEM_W(VW), .TS_W(TW)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start          (start),
        .cfg_num_folds  (cfg_num_folds),
        .cfg_num_ts     (cfg_num_ts),
        .cfg_vth        (cfg_vth),
        .cfg_reset_mode (cfg_reset_mode),
`ifdef SNN_LEAK_EN
        .cfg_leak_shift (4'd0),
`endif
        .bus            (bus),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    // Consumer side: random back-pressure unless the driver forces a stall
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = force_low ? 1'b0 : ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: compare every presented spike vector (held or handed off) against the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (nrst && bus.out_valid) begin
                checkOutput("in_ready_low_in_fire", {31'd0, bus.in_ready}, 32'd0);
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    checkOutput("out_spikes", {23'd0, bus.out_spikes}, {23'd0, sbq[0].spk});
                    checkOutput("out_ts", {28'd0, bus.out_ts}, {28'd0, sbq[0].ts});
                    if (bus.out_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: time limit reached");
        finishTest();
    end

    task automatic genBeat(input int pat, input int warg, input int ts, input int last_ts);
        for (int p = 0; p < NP; p++) begin
            for (int c = 0; c < NC; c++) begin
                case (pat)
                    1: begin
                        sp[p][c] = (p == 0 && c < 4) ? 1 : 0;
                        wt[p][c] = (p == 0 && c < 4) ? warg : 0;
                    end
                    2: begin
                        sp[p][c] = 1;
                        wt[p][c] = (ts == last_ts) ? 127 : -128;
                    end
                    3: begin
                        sp[p][c] = (p == 1 && c == 0) ? 1 : 0;
                        wt[p][c] = (p == 1 && c == 0) ? 5 : 0;
                    end
                    default: begin
                        sp[p][c] = int'($urandom_range(0, 1));
                        wt[p][c] = int'($urandom_range(0, 200)) - 80;
                    end
                endcase
                bus.in_spikes[p*NC + c] = sp[p][c][0];
                bus.in_weights[(p*NC + c)*WW +: WW] = 8'(wt[p][c]);
            end
        end
    endtask

    task automatic applyStimulus(input int folds_cfg, input int ts_cfg, input int vth,
                                 input int mode, input int pat, input int warg,
                                 input bit stall, input int abort_ts);
        int   f_eff, t_eff, guard, v;
        exp_t e;
        f_eff = (folds_cfg == 0) ? 1 : (folds_cfg > MF) ? MF : folds_cfg;
        t_eff = (ts_cfg == 0) ? 1 : ts_cfg;
        for (int p = 0; p < NP; p++) vmem_m[p] = 0;
        force_low = stall;
        cfg_num_folds  = 3'(folds_cfg);
        cfg_num_ts     = 4'(ts_cfg);
        cfg_vth        = 11'(vth);
        cfg_reset_mode = mode[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 0; t < t_eff; t++) begin
            for (int p = 0; p < NP; p++) psum_m[p] = 0;
            for (int f = 0; f < f_eff; f++) begin
                if (t == abort_ts && f == 1) begin
                    checkOutput("ts_before_abort", {28'd0, bus.out_ts}, 32'(abort_ts));
                    #2;
                    nrst = 1'b0;
                    #1;
                    checkOutput("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
                    checkOutput("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
                    checkOutput("abort_done", {31'd0, done}, 32'd0);
                    checkOutput("abort_cfg_err", {31'd0, cfg_err}, 32'd0);
                    checkOutput("abort_out_spikes", {23'd0, bus.out_spikes}, 32'd0);
                    checkOutput("abort_out_ts", {28'd0, bus.out_ts}, 32'd0);
                    sbq.delete();
                    bus.in_valid = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    nrst = 1'b1;
                    return;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                genBeat(pat, warg, t, t_eff - 1);
                bus.in_valid = 1'b1;
                // A start pulse mid-job with different folds must be ignored
                if (pat == 0 && t == 1 && f == 0) begin
                    start = 1'b1;
                    cfg_num_folds = 3'($urandom_range(1, 4));
                    cfg_vth = 11'($urandom_range(1, 2047));
                end
                guard = 0;
                while (1) begin
                    @(negedge clk);
                    if (bus.in_ready) break;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (guard > 200) begin
                        checkOutput("beat_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
                        finishTest();
                    end
                end
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                start = 1'b0;
                for (int p = 0; p < NP; p++)
                    for (int c = 0; c < NC; c++)
                        if (sp[p][c] != 0) psum_m[p] += wt[p][c];
                if (f == f_eff - 1) begin
                    for (int p = 0; p < NP; p++) begin
                        v = vmem_m[p] + psum_m[p];
                        if (v > VLIMIT) v = VLIMIT;
                        if (v < -VLIMIT) v = -VLIMIT;
                        e.spk[p] = (v >= vth);
                        vmem_m[p] = (v >= vth) ? ((mode != 0) ? 0 : v - vth) : v;
                    end
                    e.ts = 4'(t);
                    sbq.push_back(e);
                    @(negedge clk);
                    checkOutput("fire_latency", {31'd0, bus.out_valid}, 32'd1);
                    if (stall && t == 0) begin
                        repeat (5) begin
                            @(negedge clk);
                            checkOutput("stall_hold_valid", {31'd0, bus.out_valid}, 32'd1);
                        end
                    end
                    @(posedge clk);
                    #1;
                    force_low = 1'b0;
                end
            end
        end
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            if (done) break;
            guard++;
        end
        checkOutput("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_spikes  = '0;
        bus.in_weights = '0;
        #1;
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
        checkOutput("reset_out_spikes", {23'd0, bus.out_spikes}, 32'd0);
        checkOutput("reset_out_ts", {28'd0, bus.out_ts}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed jobs");
        applyStimulus(1, 1, 10, 0, 1, 3, 0, -1);
        applyStimulus(1, 1, 10, 1, 1, 3, 0, -1);
        applyStimulus(1, 2, 10, 0, 1, 2, 0, -1);
        applyStimulus(4, 2, 25, 0, 3, 0, 0, -1);
        applyStimulus(1, 3, 10, 0, 1, 3, 1, -1);
        applyStimulus(0, 0, 10, 0, 1, 3, 0, -1);
        checkOutput("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        applyStimulus(6, 3, 2047, 0, 2, 0, 0, -1);
        checkOutput("cfg_err_set", {31'd0, cfg_err}, 32'd1);

        $display("[TB] random jobs");
        for (int j = 0; j < 15; j++)
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                          int'($urandom_range(1, 600)), int'($urandom_range(0, 1)), 0, 0, 0, -1);

        $display("[TB] abort mid-job");
        applyStimulus(3, 4, 300, 0, 0, 0, 0, 2);
        applyStimulus(1, 1, 10, 0, 1, 3, 0, -1);
        for (int j = 0; j < 5; j++)
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                          int'($urandom_range(1, 600)), int'($urandom_range(0, 1)), 0, 0, 0, -1);
        finishTest();
    end
endmodule
